// File: rtl/srff_driver_pkg.sv
// Shared definitions for the gated SR latch driver.
//   state_t   : controller states
//   DEF_*     : default phase lengths, retry bound and counter width
//   fb_match  : true when the latch feedback agrees with the requested level
package srff_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;
  localparam int DEF_MAX_RETRY = 3;
  localparam int DEF_CNT_W     = 4;

  // q must equal the target and nq its complement; q==nq can never match.
  function automatic logic fb_match(input logic q_fb, input logic nq_fb, input logic target);
    return (q_fb == target) && (nq_fb == ~target);
  endfunction

endpackage

// File: rtl/srff_driver_if.sv
// Request / latch bundle between a requester (master) and srff_driver (slave).
//   req_valid, req_val, err_clr : requester -> driver
//   req_ready, busy, done, err  : driver -> requester status
//   s, r, c                     : driver -> latch inputs
//   q_fb, nq_fb                 : latch -> driver feedback
interface srff_driver_if;
  logic req_valid;
  logic req_val;
  logic req_ready;
  logic err_clr;
  logic q_fb;
  logic nq_fb;
  logic s;
  logic r;
  logic c;
  logic busy;
  logic done;
  logic err;

  modport master (
    output req_valid, req_val, err_clr, q_fb, nq_fb,
    input  req_ready, s, r, c, busy, done, err
  );

  modport slave (
    input  req_valid, req_val, err_clr, q_fb, nq_fb,
    output req_ready, s, r, c, busy, done, err
  );
endinterface

// File: rtl/srff_phase_timer.sv
// Loadable down-counter timing one controller phase.
//   clk, rst : clock, synchronous active-high reset
//   load     : start a phase of len cycles (len in 1..2^CNT_W)
//   len      : phase length in cycles
//   en       : count down one cycle
//   last     : high during the final cycle of the phase
// The counter holds the number of cycles remaining after the current one, so
// a length of 2^CNT_W still fits in CNT_W bits.
module srff_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [CNT_W:0] len,
  input  logic           en,
  output logic           last
);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W:0]   len_m1_s;

  // Remaining-cycles value loaded at the start of a phase.
  always_comb begin
    len_m1_s = len - (CNT_W+1)'(1);
  end

  // Down-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= len_m1_s[CNT_W-1:0];
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == '0);

endmodule

// File: rtl/srff_driver.sv
// Drives s/r/c of a gated SR latch from a level request and verifies q/nq.
//   clk, rst : clock, synchronous active-high reset
//   bus      : srff_driver_if.slave (request handshake, latch drive, feedback)
// Each attempt is SETUP (s/r stable, c low), PULSE (c high), HOLD (c low),
// then CHECK (all low, feedback sampled). Failed checks retry up to MAX_RETRY
// times before parking in ERR until err_clr. All outputs are registered and
// are updated in the same edge as the state, so they always match it.
module srff_driver
  import srff_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int MAX_RETRY = DEF_MAX_RETRY,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  srff_driver_if.slave bus
);

  localparam logic [CNT_W:0]   SETUP_LEN = (CNT_W+1)'(SETUP_CYC);
  localparam logic [CNT_W:0]   PULSE_LEN = (CNT_W+1)'(PULSE_CYC);
  localparam logic [CNT_W:0]   HOLD_LEN  = (CNT_W+1)'(HOLD_CYC);
  localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRY);

  state_t           state_r;
  logic             target_r;
  logic [CNT_W-1:0] retry_r;
  logic             s_r, r_r, c_r;
  logic             busy_r, done_r, err_r, req_ready_r;

  logic             transfer_s;
  logic             fb_ok_s;
  logic             can_retry_s;
  logic             timer_load_s;
  logic [CNT_W:0]   timer_len_s;
  logic             timer_en_s;
  logic             timer_last_s;

  // Handshake and feedback qualifiers used by both the timer control and FSM.
  always_comb begin
    transfer_s  = bus.req_valid && req_ready_r && (state_r == IDLE);
    fb_ok_s     = fb_match(bus.q_fb, bus.nq_fb, target_r);
    can_retry_s = (retry_r < RETRY_MAX);
  end

  // Timer control: load on every phase entry, count down inside a phase.
  always_comb begin
    timer_load_s = 1'b0;
    timer_len_s  = SETUP_LEN;
    timer_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          timer_load_s = 1'b1;
          timer_len_s  = SETUP_LEN;
        end else begin
          timer_load_s = 1'b0;
        end
      end
      SETUP: begin
        if (timer_last_s) begin
          timer_load_s = 1'b1;
          timer_len_s  = PULSE_LEN;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      PULSE: begin
        if (timer_last_s) begin
          timer_load_s = 1'b1;
          timer_len_s  = HOLD_LEN;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      HOLD: begin
        timer_en_s = 1'b1;
      end
      CHECK: begin
        if (!fb_ok_s && can_retry_s) begin
          timer_load_s = 1'b1;
          timer_len_s  = SETUP_LEN;
        end else begin
          timer_load_s = 1'b0;
        end
      end
      default: begin
        timer_load_s = 1'b0;
      end
    endcase
  end

  srff_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load_s),
    .len  (timer_len_s),
    .en   (timer_en_s),
    .last (timer_last_s)
  );

  // Controller FSM with registered latch drive and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      target_r    <= 1'b0;
      retry_r     <= '0;
      s_r         <= 1'b0;
      r_r         <= 1'b0;
      c_r         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      req_ready_r <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (transfer_s) begin
            state_r     <= SETUP;
            target_r    <= bus.req_val;
            s_r         <= bus.req_val;
            r_r         <= ~bus.req_val;
            c_r         <= 1'b0;
            busy_r      <= 1'b1;
            req_ready_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          if (timer_last_s) begin
            state_r <= PULSE;
            c_r     <= 1'b1;
          end else begin
            state_r <= SETUP;
          end
        end
        PULSE: begin
          if (timer_last_s) begin
            state_r <= HOLD;
            c_r     <= 1'b0;
          end else begin
            state_r <= PULSE;
          end
        end
        HOLD: begin
          if (timer_last_s) begin
            state_r <= CHECK;
            s_r     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        CHECK: begin
          if (fb_ok_s) begin
            state_r     <= IDLE;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            retry_r     <= '0;
          end else if (can_retry_s) begin
            // s/r were both low in CHECK, so re-driving them here is safe.
            state_r <= SETUP;
            retry_r <= retry_r + CNT_W'(1);
            s_r     <= target_r;
            r_r     <= ~target_r;
          end else begin
            state_r <= ERR;
            err_r   <= 1'b1;
          end
        end
        ERR: begin
          if (bus.err_clr) begin
            state_r     <= IDLE;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
            retry_r     <= '0;
          end else begin
            state_r <= ERR;
          end
        end
        default: begin
          state_r     <= IDLE;
          s_r         <= 1'b0;
          r_r         <= 1'b0;
          c_r         <= 1'b0;
          busy_r      <= 1'b0;
          err_r       <= 1'b0;
          req_ready_r <= 1'b1;
          retry_r     <= '0;
        end
      endcase
    end
  end

  assign bus.s         = s_r;
  assign bus.r         = r_r;
  assign bus.c         = c_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.req_ready = req_ready_r;

endmodule
